// File: rtl/am2911_pkg.sv
// Shared encodings for the Am2911 next-address controller: op codes, slice mux
// selects, controller states and the bundled slice control word.
package am2911_pkg;

  localparam logic [3:0] OP_CONT = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'h1;
  localparam logic [3:0] OP_CJMP = 4'h2;
  localparam logic [3:0] OP_JSR  = 4'h3;
  localparam logic [3:0] OP_CJSR = 4'h4;
  localparam logic [3:0] OP_RTS  = 4'h5;
  localparam logic [3:0] OP_CRTS = 4'h6;
  localparam logic [3:0] OP_LDAR = 4'h7;
  localparam logic [3:0] OP_JAR  = 4'h8;
  localparam logic [3:0] OP_LOOP = 4'h9;
  localparam logic [3:0] OP_PUSH = 4'hA;
  localparam logic [3:0] OP_POP  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hC;

  typedef enum logic [1:0] {
    SEL_PC  = 2'b00,
    SEL_AR  = 2'b01,
    SEL_STK = 2'b10,
    SEL_D   = 2'b11
  } sel_e;

  typedef enum logic [1:0] {
    ST_RESET_HOLD,
    ST_RUN,
    ST_HALT,
    ST_FAULT
  } state_e;

  // zero, re and fe are active-low, exactly as the slices see them
  typedef struct packed {
    sel_e sel;
    logic zero;
    logic cin;
    logic re;
    logic fe;
    logic pup;
  } ctl_t;

  localparam ctl_t CTL_DEFAULT = '{sel: SEL_PC, zero: 1'b1, cin: 1'b1, re: 1'b1, fe: 1'b1, pup: 1'b0};
  localparam ctl_t CTL_HOLD    = '{sel: SEL_PC, zero: 1'b1, cin: 1'b0, re: 1'b1, fe: 1'b1, pup: 1'b0};
  localparam ctl_t CTL_PARK    = '{sel: SEL_PC, zero: 1'b0, cin: 1'b0, re: 1'b1, fe: 1'b1, pup: 1'b0};

endpackage

// File: rtl/am2911_seq_ctrl_if.sv
// Pipeline-register fields in, shared slice control bundle out.
interface am2911_seq_ctrl_if #(
  parameter int NUM_COND = 7
);
  localparam int SEL_W = $clog2(NUM_COND + 1);

  logic [3:0]          op;
  logic [SEL_W-1:0]    cond_sel;
  logic                cond_pol;
  logic [NUM_COND-1:0] cond_i;
  logic                stall_i;
  logic                run_i;
  logic                fault_clr;

  logic s0;
  logic s1;
  logic zero;
  logic cin;
  logic re;
  logic fe;
  logic pup;

  modport master (
    output op, cond_sel, cond_pol, cond_i, stall_i, run_i, fault_clr,
    input  s0, s1, zero, cin, re, fe, pup
  );

  modport slave (
    input  op, cond_sel, cond_pol, cond_i, stall_i, run_i, fault_clr,
    output s0, s1, zero, cin, re, fe, pup
  );

endinterface

// File: rtl/am2911_stack_tracker.sv
// Shadow of the 2911 stack file depth; flags pushes into a full file and pops
// from an empty one so the caller can suppress fe in the same cycle.
module am2911_stack_tracker #(
  parameter int STACK_DEPTH = 4
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               push,
  input  logic                               pop,
  input  logic                               clr,
  output logic                               suppress,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               ovf,
  output logic                               unf
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic full;
  logic empty;
  logic ovf_now;
  logic unf_now;

  assign full     = (depth == DEPTH_W'(STACK_DEPTH));
  assign empty    = (depth == '0);
  assign ovf_now  = push & full;
  assign unf_now  = pop & empty;
  assign suppress = ovf_now | unf_now;

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      depth <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (clr) begin
      depth <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      if (push && !full) begin
        depth <= depth + DEPTH_W'(1);
      end else if (pop && !empty) begin
        depth <= depth - DEPTH_W'(1);
      end
      if (ovf_now) ovf <= 1'b1;
      if (unf_now) unf <= 1'b1;
    end
  end

endmodule

// File: rtl/am2911_seq_ctrl.sv
// Next-address controller for cascaded Am2911 slices. Define SEQ_TRACE_EN to
// add the upc_count / fault_op trace outputs.
module am2911_seq_ctrl
  import am2911_pkg::*;
#(
  parameter int STACK_DEPTH       = 4,
  parameter int RESET_HOLD_CYCLES = 2,
  parameter int NUM_COND          = 7
) (
  input  logic                             clock,
  input  logic                             reset_n,
  am2911_seq_ctrl_if.slave                 bus,
  output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
  output logic                             stack_ovf,
  output logic                             stack_unf,
  output logic                             halted
`ifdef SEQ_TRACE_EN
  ,
  output logic [15:0]                      upc_count,
  output logic [3:0]                       fault_op
`endif
);

  localparam int SEL_W  = $clog2(NUM_COND + 1);
  localparam int HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);

  state_e state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_done;

  logic [2**SEL_W-1:0] cond_ext;
  logic                cond;

  ctl_t dec_ctl;
  ctl_t ctl;
  logic dec_push, dec_pop, dec_halt;
  logic active, push_req, pop_req, trk_clr, stk_fault;

  // Select values at or above NUM_COND read as constant true.
  assign cond_ext = {{(2**SEL_W - NUM_COND){1'b1}}, bus.cond_i};
  assign cond     = bus.cond_pol ^ cond_ext[bus.cond_sel];

  // NOTE: every always_comb output is given a default first, so no path can infer a latch.
  always_comb begin
    dec_ctl  = CTL_DEFAULT;
    dec_push = 1'b0;
    dec_pop  = 1'b0;
    dec_halt = 1'b0;
    case (bus.op)
      OP_CONT: ;
      OP_JMP:  dec_ctl.sel = SEL_D;
      OP_CJMP: dec_ctl.sel = cond ? SEL_D : SEL_PC;
      OP_JSR: begin
        dec_ctl.sel = SEL_D;
        dec_push    = 1'b1;
      end
      OP_CJSR: if (cond) begin
        dec_ctl.sel = SEL_D;
        dec_push    = 1'b1;
      end
      OP_RTS: begin
        dec_ctl.sel = SEL_STK;
        dec_pop     = 1'b1;
      end
      OP_CRTS: if (cond) begin
        dec_ctl.sel = SEL_STK;
        dec_pop     = 1'b1;
      end
      OP_LDAR: dec_ctl.re  = 1'b0;
      OP_JAR:  dec_ctl.sel = SEL_AR;
      OP_LOOP: dec_ctl.sel = cond ? SEL_PC : SEL_AR;
      OP_PUSH: dec_push = 1'b1;
      OP_POP:  dec_pop  = 1'b1;
      OP_HALT: begin
        dec_ctl  = CTL_HOLD;
        dec_halt = 1'b1;
      end
      default: ;
    endcase
    dec_ctl.fe  = ~(dec_push | dec_pop);
    dec_ctl.pup = dec_push;
  end

  // Stack requests only reach the tracker on a live, unstalled RUN cycle.
  assign active    = (state == ST_RUN) && !bus.stall_i;
  assign push_req  = active & dec_push;
  assign pop_req   = active & dec_pop;
  assign trk_clr   = (state == ST_FAULT) & bus.fault_clr;
  assign hold_done = (hold_cnt == HOLD_W'(RESET_HOLD_CYCLES - 1));

  am2911_stack_tracker #(
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (push_req),
    .pop      (pop_req),
    .clr      (trk_clr),
    .suppress (stk_fault),
    .depth    (depth),
    .ovf      (stack_ovf),
    .unf      (stack_unf)
  );

  always_comb begin
    ctl       = CTL_DEFAULT;
    state_nxt = state;
    case (state)
      ST_RESET_HOLD: begin
        ctl = CTL_PARK;
        if (hold_done) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (bus.stall_i) begin
          ctl = CTL_HOLD;
        end else begin
          ctl = dec_ctl;
          if (stk_fault) begin
            ctl.fe    = 1'b1;
            state_nxt = ST_FAULT;
          end else if (dec_halt) begin
            state_nxt = ST_HALT;
          end
        end
      end
      ST_HALT: begin
        ctl = CTL_HOLD;
        if (bus.run_i) state_nxt = ST_RUN;
      end
      ST_FAULT: begin
        ctl = CTL_PARK;
        if (bus.fault_clr) state_nxt = ST_RUN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_RESET_HOLD;
      hold_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_RESET_HOLD && !hold_done) hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

  assign bus.s1   = ctl.sel[1];
  assign bus.s0   = ctl.sel[0];
  assign bus.zero = ctl.zero;
  assign bus.cin  = ctl.cin;
  assign bus.re   = ctl.re;
  assign bus.fe   = ctl.fe;
  assign bus.pup  = ctl.pup;
  assign halted   = (state == ST_HALT);

`ifdef SEQ_TRACE_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      upc_count <= '0;
      fault_op  <= '0;
    end else begin
      if (active) upc_count <= upc_count + 16'd1;
      if (state == ST_RUN && state_nxt == ST_FAULT) fault_op <= bus.op;
    end
  end
`endif

endmodule

// File: doc/am2911_seq_ctrl.md
Name: am2911_seq_ctrl

Overview:
- Next-address controller for a cascade of Am2911 microprogram sequencer slices. All slices share one control bundle.
- Decodes the 4-bit next-address op and condition-select fields from the microinstruction pipeline register into S1/S0, ZERO, CIN, RE, FE and PUP.
- Tracks stack depth, detects overflow/underflow, applies stall/halt holds and forces the post-reset start address.

Parameters:
- STACK_DEPTH, 4, physical 2911 file depth; push beyond it is overflow.
- RESET_HOLD_CYCLES, 2, cycles after reset release that ZERO stays low (address 0).
- NUM_COND, 7, number of external condition inputs; select value NUM_COND means constant true.

Ports:
- clock  in  1  system clock; sequencer slices update on the same rising edge
- reset_n  in  1  asynchronous active-low reset
- op  in  4  next-address op from the pipeline register
- cond_sel  in  3  condition select
- cond_pol  in  1  1 = invert the selected condition
- cond_i  in  NUM_COND  condition flags
- stall_i  in  1  hold the current address this cycle
- run_i  in  1  leave HALT
- fault_clr  in  1  clear a fault and leave FAULT
- s0, s1  out  1  slice mux select: 00 PC, 01 AR, 10 STACK, 11 D
- zero  out  1  active-low address force-to-zero
- cin  out  1  PC increment carry into the least-significant slice
- re  out  1  active-low AR load
- fe  out  1  active-low stack enable
- pup  out  1  1 = push, 0 = pop (valid only when fe=0)
- depth  out  3  current stack depth, 0..STACK_DEPTH
- stack_ovf, stack_unf  out  1  sticky fault flags
- halted  out  1  state == HALT

Behaviour:
- Control outputs are combinational from op, conditions, state and depth: zero-latency, valid in the cycle the microinstruction is presented. depth, flags and state are registered.
- Safe default (no stack, no AR load, PC selected): s1s0=00, zero=1, cin=1, re=1, fe=1, pup=0.
- HOLD pattern: s1s0=00, cin=0, fe=1, re=1. Slices re-emit PC and PC is unchanged.
- Condition: c = cond_pol XOR (cond_sel==NUM_COND ? 1 : cond_i[cond_sel]).
- Ops:
  - 0 CONT: default.
  - 1 JMP: sel=11.
  - 2 CJMP: sel = c ? 11 : 00.
  - 3 JSR: sel=11, fe=0, pup=1.
  - 4 CJSR: as JSR if c, else CONT.
  - 5 RTS: sel=10, fe=0, pup=0.
  - 6 CRTS: as RTS if c, else CONT.
  - 7 LDAR: CONT plus re=0.
  - 8 JAR: sel=01.
  - 9 LOOP: sel = c ? 00 : 01 (branch to AR until c).
  - A PUSH: CONT plus fe=0, pup=1.
  - B POP: CONT plus fe=0, pup=0.
  - C HALT: HOLD pattern, go to HALT.
  - D–F: treated as CONT.
- States:
  - RESET_HOLD: entered asynchronously on reset_n=0. zero=0, cin=0, fe=1, re=1. Counts RESET_HOLD_CYCLES cycles, then RUN.
  - RUN: decode op. If stall_i=1, HOLD pattern; no depth change, no transition (stall beats HALT and faults).
  - HALT: HOLD pattern. run_i=1 → RUN at the next edge; the op is decoded from that edge.
  - FAULT: zero=0, cin=0, fe=1, re=1 (parks at address 0). fault_clr=1 → RUN, flags cleared, depth=0.
- Depth:
  - Push with depth<STACK_DEPTH: depth+1. Pop with depth>0: depth−1.
  - Push at full: fe forced 1 (push suppressed), stack_ovf=1, go to FAULT.
  - Pop at depth 0: fe forced 1, stack_unf=1, go to FAULT.
  - Fault detection is combinational, so the suppression lands in the same cycle.
- Reset values: depth=0, flags=0, halted=0, state=RESET_HOLD. Outputs are therefore zero=0, cin=0, fe=1, re=1, s1s0=00, pup=0.
- Reset mid-operation clears everything immediately; any in-flight stack op is abandoned (fe=1 asynchronously).

Optional Feature:
- Macro SEQ_TRACE_EN.
- Defined: adds outputs upc_count (16 bits, wrapping) and fault_op (4 bits).
  - upc_count increments on every RUN cycle with stall_i=0.
  - fault_op latches op on entry to FAULT.
  - Both reset to 0.
- Undefined: neither port nor register exists; behaviour is otherwise identical.

Decomposition:
- Package am2911_pkg holds:
  - op encodings (OP_CONT..OP_HALT);
  - mux-select constants (SEL_PC, SEL_AR, SEL_STK, SEL_D);
  - state enum (ST_RESET_HOLD, ST_RUN, ST_HALT, ST_FAULT).
- One sub-module, am2911_stack_tracker: depth counter plus overflow/underflow detection. It takes push/pop requests and returns the suppress flag and depth.

Test Plan:
- Reset release → zero=0 for exactly 2 cycles, then op=CONT gives zero=1, cin=1, s1s0=00.
- Four JSRs → depth 1..4, each fe=0/pup=1. Fifth JSR → fe=1, stack_ovf=1, FAULT with zero=0. fault_clr → RUN, depth=0.
- RTS at depth 0 → fe=1, stack_unf=1, FAULT. With SEQ_TRACE_EN, fault_op=5.
- CJMP with cond_sel=2, cond_i[2]=1, cond_pol=0 → s1s0=11. Flip cond_pol → s1s0=00, cin=1.
- JSR with stall_i=1 for 3 cycles → HOLD pattern, depth unchanged. Stall released → push issued, depth+1.
- HALT op → halted=1 and HOLD pattern for 5 cycles; run_i pulse → halted=0 next cycle. LOOP with c=0 → s1s0=01; with c=1 → s1s0=00.
